// File: rtl/insertion_sort_p_if.sv
// Bus bundle for insertion_sort_p: toggle-coded event lines, push data,
// and the registered/derived status outputs.
// Optional feature macro: ISORT_COUNT_EN adds the 'count' signal.
interface insertion_sort_p_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             enable;
  logic             push;
  logic             pop;
  logic             clear;
  logic             sort;
  logic             descend;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             idle;
`ifdef ISORT_COUNT_EN
  logic [CW-1:0]    count;
`endif

  // Producer/consumer side.
  modport master (
    output enable, push, pop, clear, sort, descend, din,
    input  dout, full, empty, idle
`ifdef ISORT_COUNT_EN
    , count
`endif
  );

  // Sorter side.
  modport slave (
    input  enable, push, pop, clear, sort, descend, din,
    output dout, full, empty, idle
`ifdef ISORT_COUNT_EN
    , count
`endif
  );
endinterface

// File: rtl/insertion_sort_p.sv
// insertion_sort_p: buffer of DEPTH words filled and drained through
// toggle-coded events, sorted in place by a stable insertion sort doing one
// compare/shift per cycle. Ascending/descending and signed/unsigned keys.
// Optional feature macro: ISORT_COUNT_EN adds a registered live-entry count.
module insertion_sort_p #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256,
  parameter bit SIGNED = 1'b0
) (
  input logic              clk,
  input logic              rst,
  insertion_sort_p_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  // Registered state.
  state_t           state_q, state_d;
  logic [CW-1:0]    head_q, head_d;
  logic [CW-1:0]    wr_q, wr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW:0]      i_q, i_d;      // element being inserted; may reach wr
  logic [AW:0]      j_q, j_d;      // extra bit exposes the head-1 underflow
  logic [WIDTH-1:0] key_q, key_d;
  logic             dir_q, dir_d;
  logic             idle_q, idle_d;
  logic             p_push_q, p_pop_q, p_clear_q, p_sort_q;
`ifdef ISORT_COUNT_EN
  logic [CW-1:0]    count_q, count_d;
`endif

  // Buffer and its single write port.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic ev_push, ev_pop, ev_clear, ev_sort;
  logic full, empty;
  logic [WIDTH-1:0] mem_j;
  logic signed [CW+1:0] j_s, head_s;
  logic j_ge_head, key_lt, key_gt, key_precedes;

  assign ev_push  = bus.push  ^ p_push_q;
  assign ev_pop   = bus.pop   ^ p_pop_q;
  assign ev_clear = bus.clear ^ p_clear_q;
  assign ev_sort  = bus.sort  ^ p_sort_q;

  assign full  = (wr_q == CW'(DEPTH));
  assign empty = (head_q == wr_q);

  // Compare key against the entry at j, with j treated as a signed index so
  // that j = head-1 (including -1 when head = 0) stops the shift loop.
  always_comb begin
    mem_j     = mem_q[j_q[AW-1:0]];
    j_s       = (CW+2)'($signed(j_q));
    head_s    = $signed({2'b00, head_q});
    j_ge_head = (j_s >= head_s);
    if (SIGNED) begin
      key_lt = $signed(key_q) < $signed(mem_j);
      key_gt = $signed(key_q) > $signed(mem_j);
    end else begin
      key_lt = key_q < mem_j;
      key_gt = key_q > mem_j;
    end
    // Strict precedence keeps equal keys in arrival order.
    key_precedes = dir_q ? key_gt : key_lt;
  end

  // Event arbitration and sort FSM next-state (clear > sort > pop > push).
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    head_d    = head_q;
    wr_d      = wr_q;
    dout_d    = dout_q;
    i_d       = i_q;
    j_d       = j_q;
    key_d     = key_q;
    dir_d     = dir_q;
    mem_we    = 1'b0;
    mem_waddr = wr_q[AW-1:0];
    mem_wdata = bus.din;
    if (bus.enable) begin
      if (ev_clear) begin
        head_d  = '0;
        wr_d    = '0;
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ev_sort) begin
              dir_d   = bus.descend;
              i_d     = {1'b0, head_q} + (CW+1)'(1);
              state_d = S_LOAD;
            end else if (ev_pop) begin
              if (!empty) begin
                dout_d = mem_q[head_q[AW-1:0]];
                head_d = head_q + CW'(1);
              end
            end else if (ev_push) begin
              if (!full) begin
                mem_we = 1'b1;
                wr_d   = wr_q + CW'(1);
              end
            end
          end
          S_LOAD: begin
            if (i_q >= {1'b0, wr_q}) begin
              state_d = S_IDLE;
            end else begin
              key_d   = mem_q[i_q[AW-1:0]];
              j_d     = i_q[AW:0] - (AW+1)'(1);
              state_d = S_SHIFT;
            end
          end
          S_SHIFT: begin
            mem_we    = 1'b1;
            mem_waddr = j_q[AW-1:0] + AW'(1);
            if (j_ge_head && key_precedes) begin
              mem_wdata = mem_j;
              j_d       = j_q - (AW+1)'(1);
            end else begin
              mem_wdata = key_q;
              i_d       = i_q + (CW+1)'(1);
              state_d   = S_LOAD;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign idle_d = (state_d == S_IDLE);
`ifdef ISORT_COUNT_EN
  assign count_d = wr_d - head_d;
`endif

  // Control registers, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      head_q    <= '0;
      wr_q      <= '0;
      dout_q    <= '0;
      i_q       <= '0;
      j_q       <= '0;
      key_q     <= '0;
      dir_q     <= 1'b0;
      idle_q    <= 1'b1;
      p_push_q  <= 1'b0;
      p_pop_q   <= 1'b0;
      p_clear_q <= 1'b0;
      p_sort_q  <= 1'b0;
`ifdef ISORT_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      wr_q      <= wr_d;
      dout_q    <= dout_d;
      i_q       <= i_d;
      j_q       <= j_d;
      key_q     <= key_d;
      dir_q     <= dir_d;
      idle_q    <= idle_d;
      // Previous levels track every cycle, so toggles while disabled are lost.
      p_push_q  <= bus.push;
      p_pop_q   <= bus.pop;
      p_clear_q <= bus.clear;
      p_sort_q  <= bus.sort;
`ifdef ISORT_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  // Buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is not reset; head/wr alone decide which entries are live.
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.dout  = dout_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.idle  = idle_q;
`ifdef ISORT_COUNT_EN
  assign bus.count = count_q;
`endif
endmodule

// File: tb/tb_insertion_sort_p.sv
// Self-checking bench for insertion_sort_p. Three instances share one
// stimulus stream: DEPTH=16 unsigned, DEPTH=16 signed, DEPTH=4 unsigned.
// A behavioural model (stable selection sort, inversion count for latency)
// predicts every output after every clock edge.
module tb_insertion_sort_p;
  localparam int W  = 16;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         push_l = 1'b0, pop_l = 1'b0, clear_l = 1'b0, sort_l = 1'b0;
  logic         dsc = 1'b0;
  logic [W-1:0] din = '0;

  insertion_sort_p_if #(.WIDTH(W), .DEPTH(16)) bus0 ();
  insertion_sort_p_if #(.WIDTH(W), .DEPTH(16)) bus1 ();
  insertion_sort_p_if #(.WIDTH(W), .DEPTH(4))  bus2 ();

  assign bus0.enable = en;  assign bus1.enable = en;  assign bus2.enable = en;
  assign bus0.push = push_l;  assign bus1.push = push_l;  assign bus2.push = push_l;
  assign bus0.pop = pop_l;  assign bus1.pop = pop_l;  assign bus2.pop = pop_l;
  assign bus0.clear = clear_l;  assign bus1.clear = clear_l;  assign bus2.clear = clear_l;
  assign bus0.sort = sort_l;  assign bus1.sort = sort_l;  assign bus2.sort = sort_l;
  assign bus0.descend = dsc;  assign bus1.descend = dsc;  assign bus2.descend = dsc;
  assign bus0.din = din;  assign bus1.din = din;  assign bus2.din = din;

  insertion_sort_p #(.WIDTH(W), .DEPTH(16), .SIGNED(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  insertion_sort_p #(.WIDTH(W), .DEPTH(16), .SIGNED(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  insertion_sort_p #(.WIDTH(W), .DEPTH(4),  .SIGNED(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference model state, one slot per instance.
  int           mdl_mem  [ND][16];
  int           mdl_head [ND];
  int           mdl_wr   [ND];
  int           mdl_busy [ND];
  logic [W-1:0] mdl_dout [ND];

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  function automatic int dep_of(int d);
    return (d == 2) ? 4 : 16;
  endfunction

  function automatic int key_of(int d, int x);
    logic [W-1:0] v;
    v = W'(x);
    return (d == 1) ? int'($signed(v)) : int'(v);
  endfunction

  function automatic bit prec(int d, int a, int b, bit desc);
    return desc ? (key_of(d, a) > key_of(d, b)) : (key_of(d, a) < key_of(d, b));
  endfunction

  // Sort the live region all at once and predict how long idle stays low.
  task automatic model_sort(int d);
    int q[$];
    int res[$];
    int n, inv, best;
    q = {};
    res = {};
    for (int k = mdl_head[d]; k < mdl_wr[d]; k++) q.push_back(mdl_mem[d][k]);
    n = q.size();
    inv = 0;
    for (int a = 0; a < n; a++)
      for (int b = a + 1; b < n; b++)
        if (prec(d, q[b], q[a], dsc)) inv++;
    while (q.size() > 0) begin
      best = 0;
      for (int k = 1; k < q.size(); k++)
        if (prec(d, q[k], q[best], dsc)) best = k;
      res.push_back(q[best]);
      q.delete(best);
    end
    for (int k = 0; k < n; k++) mdl_mem[d][mdl_head[d] + k] = res[k];
    mdl_busy[d] = 1 + ((n > 1) ? 2 * (n - 1) : 0) + inv;
  endtask

  task automatic model_edge(input bit ep, eo, ec, es);
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        mdl_head[d] = 0; mdl_wr[d] = 0; mdl_dout[d] = '0; mdl_busy[d] = 0;
      end else if (en) begin
        if (ec) begin
          mdl_head[d] = 0; mdl_wr[d] = 0; mdl_busy[d] = 0;
        end else if (mdl_busy[d] > 0) begin
          mdl_busy[d]--;
        end else if (es) begin
          model_sort(d);
        end else if (eo) begin
          if (mdl_head[d] < mdl_wr[d]) begin
            mdl_dout[d] = W'(mdl_mem[d][mdl_head[d]]);
            mdl_head[d]++;
          end
        end else if (ep) begin
          if (mdl_wr[d] < dep_of(d)) begin
            mdl_mem[d][mdl_wr[d]] = int'(din);
            mdl_wr[d]++;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int d, logic [W-1:0] o_dout, logic o_full, logic o_empty,
                           logic o_idle, logic [31:0] o_cnt);
    check($sformatf("dout%0d", d),  32'(o_dout),  32'(mdl_dout[d]));
    check($sformatf("full%0d", d),  32'(o_full),  32'(mdl_wr[d] == dep_of(d)));
    check($sformatf("empty%0d", d), 32'(o_empty), 32'(mdl_head[d] == mdl_wr[d]));
    check($sformatf("idle%0d", d),  32'(o_idle),  32'(mdl_busy[d] == 0));
`ifdef ISORT_COUNT_EN
    check($sformatf("count%0d", d), o_cnt, 32'(mdl_wr[d] - mdl_head[d]));
`endif
  endtask

  task automatic check_all();
`ifdef ISORT_COUNT_EN
    check_dut(0, bus0.dout, bus0.full, bus0.empty, bus0.idle, 32'(bus0.count));
    check_dut(1, bus1.dout, bus1.full, bus1.empty, bus1.idle, 32'(bus1.count));
    check_dut(2, bus2.dout, bus2.full, bus2.empty, bus2.idle, 32'(bus2.count));
`else
    check_dut(0, bus0.dout, bus0.full, bus0.empty, bus0.idle, 32'd0);
    check_dut(1, bus1.dout, bus1.full, bus1.empty, bus1.idle, 32'd0);
    check_dut(2, bus2.dout, bus2.full, bus2.empty, bus2.idle, 32'd0);
`endif
  endtask

  // One clock: set levels at the falling edge, model the rising edge,
  // compare at the next falling edge.
  task automatic step(input bit r, tp, to, tc, ts, input int dv, input bit ds);
    rst = r;
    din = W'(dv);
    dsc = ds;
    if (r) begin
      push_l = 1'b0; pop_l = 1'b0; clear_l = 1'b0; sort_l = 1'b0;
    end else begin
      if (tp) push_l  = ~push_l;
      if (to) pop_l   = ~pop_l;
      if (tc) clear_l = ~clear_l;
      if (ts) sort_l  = ~sort_l;
    end
    @(posedge clk);
    model_edge(!r && tp, !r && to, !r && tc, !r && ts);
    @(negedge clk);
    check_all();
  endtask

  task automatic nop();           step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, dsc); endtask
  task automatic push_v(int v);   step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v, dsc); endtask
  task automatic pop1();          step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, dsc); endtask
  task automatic sort1(bit ds);   step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, ds);  endtask
  task automatic clear1();        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, dsc); endtask
  task automatic reset1();        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, dsc); endtask

  function automatic bit any_busy();
    for (int d = 0; d < ND; d++) if (mdl_busy[d] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Bounded by the model's own latency prediction; a stuck DUT shows up as
  // idle mismatches, never as a hang.
  task automatic drain();
    for (int k = 0; k < 2000 && any_busy(); k++) nop();
  endtask

  initial begin
    @(negedge clk);
    reset1();
    reset1();

    // Ascending sort of 30,10,20,10,5 (DEPTH=4 instance drops the fifth).
    push_v(30); push_v(10); push_v(20); push_v(10); push_v(5);
    sort1(1'b0);
    drain();
    for (int k = 0; k < 6; k++) pop1();
    clear1();

    // Descending with signed keys: -1, 3, -32768.
    push_v(16'hFFFF); push_v(3); push_v(16'h8000);
    sort1(1'b1);
    drain();
    for (int k = 0; k < 3; k++) pop1();
    clear1();

    // Clear three cycles into sorting 8 entries, then a pop on empty.
    pop1();
    for (int k = 0; k < 8; k++) push_v(int'($urandom_range(0, 65535)));
    sort1(1'b0);
    nop(); nop();
    clear1();
    nop();
    pop1();

    // Push+pop in one cycle with 2 entries; push while sorting is dropped.
    push_v(7); push_v(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9, dsc);
    push_v(4);
    sort1(1'b0);
    push_v(1);
    drain();
    for (int k = 0; k < 3; k++) pop1();
    clear1();

    // Sort on a single entry.
    push_v(42);
    sort1(1'b1);
    nop(); nop();
    pop1();
    clear1();

    // Freeze a 6-entry sort with enable low for 10 cycles, including a
    // toggle that must be lost.
    for (int k = 0; k < 6; k++) push_v(int'($urandom_range(0, 65535)));
    sort1(1'b1);
    nop(); nop(); nop();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) pop1();
      else nop();
    end
    en = 1'b1;
    drain();
    for (int k = 0; k < 6; k++) pop1();

    // Reset in the middle of a sort.
    for (int k = 0; k < 5; k++) push_v(int'($urandom_range(0, 65535)));
    sort1(1'b0);
    nop(); nop();
    reset1();
    nop();

    // Random traffic with small key range so duplicates occur.
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 9) != 0);
      step(1'b0,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 19) == 0,
           ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 65535)),
           $urandom_range(0, 1) != 0);
    end
    en = 1'b1;
    drain();
    for (int k = 0; k < 17; k++) pop1();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
